// File: rtl/lowres_data_bridge.sv
// lowres_data_bridge
// 32-bit data-path companion to the low-res opcode adapter. It snoops the
// opcode stream and moves exactly the payload each opcode implies:
//   ingest : host stream (s_*)      -> in-FIFO  -> core_data_in
//   dump   : core_data_out          -> out-FIFO -> host stream (m_*)
// A DEPTH-entry FIFO per direction decouples host and core backpressure.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   op_in[3:0], op_valid_in      opcode issued to the core (one-cycle valid)
//   s_valid/s_ready/s_data       host -> bridge stream
//   m_valid/m_ready/m_data       bridge -> host stream
//   core_data_in/core_valid_in/core_ready_rcv    bridge -> core stream
//   core_data_out/core_valid_out/core_ready_out  core -> bridge stream
//   busy                         transfer in progress
//   xfer_done                    one-cycle pulse when a transfer completes
//   err_proto                    sticky: opcode seen while not IDLE
//   state_dbg[2:0]               current FSM state, for checkers
//
// Handshake rule (all four streams): a word moves on a clk edge where
// valid && ready are both high; a raised valid holds with stable data until
// accepted, and ready never depends combinationally on the partner's valid.

module lowres_data_bridge #(
  parameter int DEPTH      = 4,
  parameter int PK_WORDS   = 328,
  parameter int SK_WORDS   = 632,
  parameter int SIG_WORDS  = 605,
  parameter int SEED_WORDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_in,
  input  logic        op_valid_in,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [31:0] core_data_in,
  output logic        core_valid_in,
  input  logic        core_ready_rcv,
  input  logic [31:0] core_data_out,
  input  logic        core_valid_out,
  output logic        core_ready_out,
  output logic        busy,
  output logic        xfer_done,
  output logic        err_proto,
  output logic [2:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IN_LEN    = 3'd1,
    IN_XFER   = 3'd2,
    IN_DRAIN  = 3'd3,
    OUT_XFER  = 3'd4,
    OUT_DRAIN = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Payload size in words for the low two opcode bits.
  function automatic logic [CNT_W-1:0] words_for(input logic [1:0] sel);
    case (sel)
      2'b00:   return CNT_W'(PK_WORDS);
      2'b01:   return CNT_W'(SK_WORDS);
      2'b10:   return CNT_W'(SIG_WORDS);
      default: return CNT_W'(SEED_WORDS);
    endcase
  endfunction

  // ---------------- in-FIFO (host -> core) ----------------
  logic [31:0] in_mem [DEPTH];
  logic [AW-1:0] in_wr, in_rd;
  logic [AW:0]   in_count;
  logic          in_full, in_push, in_pop;

  assign in_full       = (in_count == (AW+1)'(DEPTH));
  assign core_valid_in = (in_count != '0);
  // Gate the read data so the output is 0 whenever nothing is offered.
  assign core_data_in  = core_valid_in ? in_mem[in_rd] : '0;

  // The length word in IN_LEN is consumed without entering the FIFO.
  assign s_ready = (state == IN_LEN) || ((state == IN_XFER) && !in_full);
  assign in_push = s_valid && s_ready && (state == IN_XFER);
  assign in_pop  = core_valid_in && core_ready_rcv;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr    <= '0;
      in_rd    <= '0;
      in_count <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + 1'b1;
      if (in_pop)  in_rd <= in_rd + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + 1'b1;
        2'b01:   in_count <= in_count - 1'b1;
        default: in_count <= in_count;
      endcase
    end
  end

  // ---------------- out-FIFO (core -> host) ----------------
  logic [31:0] out_mem [DEPTH];
  logic [AW-1:0] out_wr, out_rd;
  logic [AW:0]   out_count;
  logic          out_full, out_push, out_pop;

  assign out_full       = (out_count == (AW+1)'(DEPTH));
  assign m_valid        = (out_count != '0);
  assign m_data         = m_valid ? out_mem[out_rd] : '0;
  assign core_ready_out = (state == OUT_XFER) && !out_full;
  assign out_push       = core_valid_out && core_ready_out;
  assign out_pop        = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= core_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + 1'b1;
        2'b01:   out_count <= out_count - 1'b1;
        default: out_count <= out_count;
      endcase
    end
  end

  // ---------------- transfer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err_proto <= 1'b0;
    end else begin
      // An opcode outside IDLE (DONE included) is flagged and otherwise ignored.
      if (op_valid_in && (state != IDLE)) err_proto <= 1'b1;

      case (state)
        IDLE: begin
          if (op_valid_in) begin
            if (op_in[3:2] == 2'b11) begin
              cnt   <= words_for(op_in[1:0]);
              state <= IN_XFER;
            end else if (op_in[3:2] == 2'b10) begin
              cnt   <= words_for(op_in[1:0]);
              state <= OUT_XFER;
            end else if (op_in == 4'b0001) begin
              state <= IN_LEN;
            end else if (op_in == 4'b0100) begin
              // Verify returns a single result word.
              cnt   <= CNT_W'(1);
              state <= OUT_XFER;
            end
          end
        end
        IN_LEN: begin
          if (s_valid) begin
            cnt   <= s_data[CNT_W-1:0];
            state <= (s_data[CNT_W-1:0] == '0) ? DONE : IN_XFER;
          end
        end
        IN_XFER: begin
          if (in_push) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= IN_DRAIN;
          end
        end
        IN_DRAIN: begin
          // Empty means the final core handshake has already happened.
          if (in_count == '0) state <= DONE;
        end
        OUT_XFER: begin
          if (out_push) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= OUT_DRAIN;
          end
        end
        OUT_DRAIN: begin
          if (out_count == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != DONE);
  assign xfer_done = (state == DONE);
  assign state_dbg = state;

endmodule
